// File: rtl/red_pitaya_mux_sequencer_pkg.sv
// Shared mode codes and sequencer state encodings (also used by register-bank decode).
package red_pitaya_mux_sequencer_pkg;

  localparam logic [1:0] MODE_SCAN  = 2'd0;
  localparam logic [1:0] MODE_SWEEP = 2'd1;
  localparam logic [1:0] MODE_FIXED = 2'd2;
  localparam logic [1:0] MODE_IDLE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DWELL  = 2'd2
  } seq_state_e;

  // Action scheduled for the edge that ends the current channel's dwell
  typedef enum logic [1:0] {
    ACT_IDLE   = 2'd0,
    ACT_SETTLE = 2'd1,
    ACT_DWELL  = 2'd2
  } bnd_act_e;

endpackage

// File: rtl/red_pitaya_mux_sequencer_if.sv
// Control/status bundle between the housekeeping register bank and the mux sequencer.
interface red_pitaya_mux_sequencer_if #(
  parameter int unsigned CHNL = 8,
  parameter int unsigned MAW  = 3,
  parameter int unsigned CW   = 16,
  parameter int unsigned SW   = 8
);

  logic            enable_i;
  logic [1:0]      mode_i;
  logic            start_i;
  logic [CHNL-1:0] active_channels_i;
  logic [MAW-1:0]  fixed_chnl_i;
  logic [SW-1:0]   settle_i;
  logic [CW-1:0]   dwell_i;
  logic [MAW-1:0]  mux_addr_o;
  logic            signal_stable_o;
  logic            chnl_done_o;
  logic            sweep_done_o;
  logic            busy_o;

  modport master (
    output enable_i, mode_i, start_i, active_channels_i, fixed_chnl_i, settle_i, dwell_i,
    input  mux_addr_o, signal_stable_o, chnl_done_o, sweep_done_o, busy_o
  );

  modport slave (
    input  enable_i, mode_i, start_i, active_channels_i, fixed_chnl_i, settle_i, dwell_i,
    output mux_addr_o, signal_stable_o, chnl_done_o, sweep_done_o, busy_o
  );

endinterface

// File: rtl/red_pitaya_mux_next_chnl.sv
// Cyclic priority search: first set mask bit strictly after cur_i, wrapping back to cur_i itself.
module red_pitaya_mux_next_chnl #(
  parameter int unsigned CHNL = 8,
  parameter int unsigned MAW  = 3
) (
  input  logic [CHNL-1:0] mask_i,
  input  logic [MAW-1:0]  cur_i,
  output logic [MAW-1:0]  next_o,
  output logic            found_o,
  output logic            wrapped_o
);

  logic [MAW-1:0] idx;

  // Scan distances 1..CHNL; the nearest set bit wins
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    idx     = '0;
    for (int unsigned d = 1; d <= CHNL; d++) begin
      idx = MAW'((32'(cur_i) + d) % CHNL);
      if (!found_o && mask_i[idx]) begin
        next_o  = idx;
        found_o = 1'b1;
      end
    end
    wrapped_o = found_o && (next_o <= cur_i);
  end

endmodule

// File: rtl/red_pitaya_mux_sequencer.sv
// FADS analog mux sequencer: scans the channel mask with programmable settle/dwell times.
module red_pitaya_mux_sequencer
  import red_pitaya_mux_sequencer_pkg::*;
#(
  parameter int unsigned CHNL = 8,
  parameter int unsigned MAW  = 3,
  parameter int unsigned CW   = 16,
  parameter int unsigned SW   = 8
) (
  input logic                        adc_clk_i,
  input logic                        adc_rstn_i,
  red_pitaya_mux_sequencer_if.slave  bus
);

  localparam int unsigned   CNTW    = (CW > SW) ? CW : SW;
  localparam logic [MAW-1:0] LAST_CH = MAW'(CHNL - 1);

  seq_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [MAW-1:0]  addr_q, addr_d;
  logic            stable_q, stable_d;
  logic            chnl_done_q, chnl_done_d;
  logic            sweep_done_q, sweep_done_d;
  logic            busy_q, busy_d;
  bnd_act_e        plan_act_q, plan_act_d;
  logic [MAW-1:0]  plan_next_q, plan_next_d;

  logic [CNTW-1:0] settle_cnt_c, dwell_cnt_c;
  logic [MAW-1:0]  fixed_c, search_cur_c, search_next_c;
  logic            search_found_c, search_wrapped_c;
  bnd_act_e        plan_act_c;
  logic [MAW-1:0]  plan_next_c;
  logic            plan_sweep_c;
  logic            start_ok_c;

  // Counter reload values: a programmed 0 behaves as 1 cycle
  assign settle_cnt_c = (bus.settle_i == '0) ? '0 : CNTW'(bus.settle_i) - CNTW'(1);
  assign dwell_cnt_c  = (bus.dwell_i  == '0) ? '0 : CNTW'(bus.dwell_i)  - CNTW'(1);
  assign fixed_c      = (32'(bus.fixed_chnl_i) >= CHNL) ? LAST_CH : bus.fixed_chnl_i;

  // From IDLE search from the top channel so the lowest set bit is found
  assign search_cur_c = (state_q == ST_IDLE) ? LAST_CH : addr_q;

  red_pitaya_mux_next_chnl #(
    .CHNL (CHNL),
    .MAW  (MAW)
  ) u_next_chnl (
    .mask_i    (bus.active_channels_i),
    .cur_i     (search_cur_c),
    .next_o    (search_next_c),
    .found_o   (search_found_c),
    .wrapped_o (search_wrapped_c)
  );

  // Decide what follows the current channel; captured on entry to its last dwell cycle
  always_comb begin
    plan_act_c   = ACT_IDLE;
    plan_next_c  = addr_q;
    plan_sweep_c = 1'b0;
    case (bus.mode_i)
      MODE_SCAN: begin
        if (search_found_c) begin
          plan_next_c  = search_next_c;
          plan_sweep_c = search_wrapped_c;
          plan_act_c   = (search_next_c == addr_q) ? ACT_DWELL : ACT_SETTLE;
        end
      end
      MODE_SWEEP: begin
        if (search_found_c) begin
          if (search_wrapped_c) begin
            plan_sweep_c = 1'b1;
          end else begin
            plan_next_c = search_next_c;
            plan_act_c  = ACT_SETTLE;
          end
        end
      end
      MODE_FIXED: begin
        plan_next_c = fixed_c;
        plan_act_c  = (fixed_c == addr_q) ? ACT_DWELL : ACT_SETTLE;
      end
      default: plan_act_c = ACT_IDLE;
    endcase
  end

  assign start_ok_c = ((bus.mode_i == MODE_SCAN)  && search_found_c) ||
                      ((bus.mode_i == MODE_SWEEP) && bus.start_i && search_found_c) ||
                       (bus.mode_i == MODE_FIXED);

  // Next-state, counter and output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    stable_d     = stable_q;
    chnl_done_d  = 1'b0;
    sweep_done_d = 1'b0;
    plan_act_d   = plan_act_q;
    plan_next_d  = plan_next_q;

    case (state_q)
      ST_IDLE: begin
        stable_d = 1'b0;
        if (bus.enable_i && start_ok_c) begin
          state_d = ST_SETTLE;
          addr_d  = (bus.mode_i == MODE_FIXED) ? fixed_c : search_next_c;
          cnt_d   = settle_cnt_c;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d  = ST_DWELL;
          stable_d = 1'b1;
          cnt_d    = dwell_cnt_c;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          case (plan_act_q)
            ACT_DWELL: cnt_d = dwell_cnt_c;
            ACT_SETTLE: begin
              state_d  = ST_SETTLE;
              addr_d   = plan_next_q;
              stable_d = 1'b0;
              cnt_d    = settle_cnt_c;
            end
            default: begin
              state_d  = ST_IDLE;
              stable_d = 1'b0;
            end
          endcase
        end
      end
      default: begin
        state_d  = ST_IDLE;
        stable_d = 1'b0;
      end
    endcase

    // Entering the last dwell cycle: flag it and lock in the boundary decision
    if ((state_d == ST_DWELL) && (cnt_d == '0)) begin
      chnl_done_d  = 1'b1;
      sweep_done_d = plan_sweep_c;
      plan_act_d   = plan_act_c;
      plan_next_d  = plan_next_c;
    end

    if (!bus.enable_i) begin
      state_d      = ST_IDLE;
      addr_d       = addr_q;
      stable_d     = 1'b0;
      chnl_done_d  = 1'b0;
      sweep_done_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      stable_q     <= 1'b0;
      chnl_done_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
      plan_act_q   <= ACT_IDLE;
      plan_next_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      stable_q     <= stable_d;
      chnl_done_q  <= chnl_done_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
      plan_act_q   <= plan_act_d;
      plan_next_q  <= plan_next_d;
    end
  end

  assign bus.mux_addr_o      = addr_q;
  assign bus.signal_stable_o = stable_q;
  assign bus.chnl_done_o     = chnl_done_q;
  assign bus.sweep_done_o    = sweep_done_q;
  assign bus.busy_o          = busy_q;

endmodule

// File: tb/tb_red_pitaya_mux_sequencer.sv
// Self-checking bench for red_pitaya_mux_sequencer (CHNL=6) against a schedule-level model.
module tb_red_pitaya_mux_sequencer;

  localparam int unsigned CHNL = 6;
  localparam int unsigned MAW  = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned SW   = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  red_pitaya_mux_sequencer_if #(.CHNL(CHNL), .MAW(MAW), .CW(CW), .SW(SW)) bus ();

  red_pitaya_mux_sequencer #(.CHNL(CHNL), .MAW(MAW), .CW(CW), .SW(SW)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rstn),
    .bus        (bus)
  );

  // {addr, stable, chnl_done, sweep_done, busy}
  function automatic logic [6:0] obs();
    return {bus.mux_addr_o, bus.signal_stable_o, bus.chnl_done_o, bus.sweep_done_o, bus.busy_o};
  endfunction

  function automatic logic [6:0] pk(int a, bit s, bit c, bit w, bit b);
    return {3'(a), s, c, w, b};
  endfunction

  function automatic int next_set(logic [5:0] m, int ch);
    for (int k = 1; k <= 6; k++) begin
      if (m[(ch + k) % 6]) return (ch + k) % 6;
    end
    return ch;
  endfunction

  function automatic int highest_set(logic [5:0] m);
    for (int k = 5; k >= 0; k--) if (m[k]) return k;
    return 0;
  endfunction

  // Expected per-cycle trace for a static configuration started from IDLE
  task automatic build_model(input int mode, input logic [5:0] m, input int fixed,
                             input int s, input int d, input int n);
    int ch, prev, nxt, se, de;
    bit sweep, finished;
    exp_q.delete();
    se = (s == 0) ? 1 : s;
    de = (d == 0) ? 1 : d;
    ch = (mode == 2) ? ((fixed > 5) ? 5 : fixed) : next_set(m, 5);
    prev = -1;
    finished = 0;
    while (exp_q.size() < n) begin
      if (finished) begin
        exp_q.push_back(pk(ch, 0, 0, 0, 0));
      end else begin
        if (ch != prev) for (int k = 0; k < se; k++) exp_q.push_back(pk(ch, 0, 0, 0, 1));
        nxt = ch;
        sweep = 0;
        if (mode == 0) begin
          nxt = next_set(m, ch);
          sweep = (nxt <= ch);
        end else if (mode == 1) begin
          nxt = next_set(m, ch);
          sweep = (ch == highest_set(m));
          finished = sweep;
        end
        for (int k = 0; k < de; k++)
          exp_q.push_back(pk(ch, 1, k == de - 1, (k == de - 1) && sweep, 1));
        prev = ch;
        if (!finished) ch = nxt;
      end
    end
  endtask

  task automatic idle_dut();
    bus.enable_i = 1'b0;
    bus.start_i  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string name, input int mode, input logic [5:0] m,
                           input int fixed, input int s, input int d, input int n,
                           input int restart_at);
    logic [6:0] got;
    bus.mode_i            = 2'(mode);
    bus.active_channels_i = m;
    bus.fixed_chnl_i      = 3'(fixed);
    bus.settle_i          = 8'(s);
    bus.dwell_i           = 16'(d);
    bus.enable_i          = 1'b1;
    bus.start_i           = (mode == 1);
    build_model(mode, m, fixed, s, d, n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL %s cycle %0d got=%b exp=%b (addr,stb,cd,sd,busy)", name, i, got, exp_q[i]);
      end
      bus.start_i = (i == restart_at);
    end
    idle_dut();
  endtask

  task automatic test_reset();
    bus.enable_i = 1'b0; bus.mode_i = 2'd0; bus.start_i = 1'b0;
    bus.active_channels_i = '0; bus.fixed_chnl_i = '0;
    bus.settle_i = '0; bus.dwell_i = '0;
    rstn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (obs() !== 7'b0) begin
        failures++;
        $display("FAIL reset got=%b exp=%b", obs(), 7'b0);
      end
    end
    rstn = 1'b1;
  endtask

  task automatic test_scan();
    run_check("scan", 0, 6'b100101, 0, 3, 10, 60, -1);
    run_check("scan_fast", 0, 6'b100101, 0, 0, 0, 20, -1);
  endtask

  task automatic test_empty_mask();
    bus.mode_i = 2'd0; bus.active_channels_i = '0; bus.enable_i = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (bus.busy_o !== 1'b0 || bus.signal_stable_o !== 1'b0) begin
        failures++;
        $display("FAIL empty_mask busy=%b stable=%b exp 0 0", bus.busy_o, bus.signal_stable_o);
      end
    end
    run_check("single_chnl", 0, 6'b001000, 0, 3, 10, 45, -1);
  endtask

  task automatic test_sweep();
    run_check("sweep", 1, 6'b010010, 0, 3, 10, 40, 5);
  endtask

  task automatic test_fixed();
    bus.mode_i = 2'd2; bus.fixed_chnl_i = 3'd3; bus.settle_i = 8'd3; bus.dwell_i = 16'd10;
    bus.active_channels_i = '0; bus.enable_i = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk); #1;
      if (e == 1 || (e >= 7 && e <= 12)) begin
        checks++;
        if (bus.mux_addr_o !== 3'd3 || bus.signal_stable_o !== (e != 1)) begin
          failures++;
          $display("FAIL fixed_hold e=%0d addr=%0d stable=%b exp addr 3", e, bus.mux_addr_o, bus.signal_stable_o);
        end
      end
      if (e == 13) begin
        checks++;
        if ({bus.mux_addr_o, bus.signal_stable_o, bus.chnl_done_o} !== {3'd3, 2'b11}) begin
          failures++;
          $display("FAIL fixed_end addr=%0d stb=%b cd=%b exp 3 1 1", bus.mux_addr_o, bus.signal_stable_o, bus.chnl_done_o);
        end
      end
      if (e == 14 || e == 17) begin
        checks++;
        if ({bus.mux_addr_o, bus.signal_stable_o, bus.busy_o} !== {3'd5, e == 17, 1'b1}) begin
          failures++;
          $display("FAIL fixed_switch e=%0d addr=%0d stb=%b busy=%b exp addr 5", e, bus.mux_addr_o, bus.signal_stable_o, bus.busy_o);
        end
      end
      if (e == 6) bus.fixed_chnl_i = 3'd7;
    end
    idle_dut();
    run_check("fixed_clamp_fast", 2, 6'b000000, 7, 0, 0, 12, -1);
  endtask

  task automatic test_midop();
    bus.mode_i = 2'd0; bus.active_channels_i = 6'b100101;
    bus.settle_i = 8'd3; bus.dwell_i = 16'd10; bus.enable_i = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    bus.enable_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL disable got=%b exp=%b", obs(), pk(0, 0, 0, 0, 0));
    end
    bus.active_channels_i = 6'b001000; bus.enable_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs() !== pk(3, 0, 0, 0, 1)) begin
      failures++;
      $display("FAIL pre_reset got=%b exp=%b", obs(), pk(3, 0, 0, 0, 1));
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs() !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=%b", obs(), 7'b0);
    end
    bus.enable_i = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dwell_change();
    int done_e[$];
    bus.mode_i = 2'd0; bus.active_channels_i = 6'b100101;
    bus.settle_i = 8'd2; bus.dwell_i = 16'd10; bus.enable_i = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (bus.chnl_done_o === 1'b1) done_e.push_back(e);
      if (e == 24) begin
        checks++;
        if (bus.busy_o !== 1'b1) begin
          failures++;
          $display("FAIL mode3_early busy=%b exp 1", bus.busy_o);
        end
      end
      if (e == 25) begin
        checks++;
        if (obs() !== pk(5, 0, 0, 0, 0)) begin
          failures++;
          $display("FAIL mode3_idle got=%b exp=%b", obs(), pk(5, 0, 0, 0, 0));
        end
      end
      if (e == 5) bus.dwell_i = 16'd4;
      if (e == 22) bus.mode_i = 2'd3;
    end
    checks++;
    if (done_e.size() != 3) begin
      failures++;
      $display("FAIL dwell_change pulses=%0d exp 3", done_e.size());
    end else begin
      checks++;
      if (done_e[0] != 12 || done_e[1] != 18 || done_e[2] != 24) begin
        failures++;
        $display("FAIL dwell_change edges=%0d,%0d,%0d exp 12,18,24", done_e[0], done_e[1], done_e[2]);
      end
    end
    idle_dut();
  endtask

  task automatic test_random();
    int mode, fixed, s, d;
    logic [5:0] m;
    for (int it = 0; it < 20; it++) begin
      mode  = int'($urandom_range(0, 2));
      m     = 6'($urandom_range(1, 63));
      fixed = int'($urandom_range(0, 7));
      s     = int'($urandom_range(0, 4));
      d     = int'($urandom_range(0, 6));
      run_check($sformatf("rand%0d_m%0d", it, mode), mode, m, fixed, s, d, 50, -1);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_empty_mask();
    test_sweep();
    test_fixed();
    test_midop();
    test_dwell_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
